// File: rtl/bsg_cordic_pkg.sv
//------------------------------------------------------------------------------
// Module : bsg_cordic_pkg
// Desc   : Shared constants and payload type for the sinh/cosh CORDIC stages.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bsg_cordic_pkg;

    localparam int c_ANS_WIDTH = 24;
    localparam int c_ANS_FRAC  = 20;
    localparam int c_ANG_WIDTH = 24;
    localparam int c_SAT_CNT_W = 16;

    // 1/K_h for the classic positive-index iteration set (~1.2075 in Q4.20);
    // pipelines with negative-index stages override the seed at the top level.
    localparam logic [c_ANS_WIDTH-1:0] c_GAIN_INV_H_STD = 24'h1351E8;
    localparam logic [c_ANG_WIDTH-1:0] c_ANG_MAX        = 24'h500000;

    typedef struct packed {
        logic [c_ANS_WIDTH-1:0] x;
        logic [c_ANS_WIDTH-1:0] y;
        logic [c_ANG_WIDTH-1:0] ang;
        logic                   sat;
    } cordic_payload_t;

endpackage

`default_nettype wire

// File: rtl/bsg_cordic_skid_buffer.sv
//------------------------------------------------------------------------------
// Module : bsg_cordic_skid_buffer
// Desc   : 2-entry valid/ready buffer; head and ready both come straight from flops.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_cordic_skid_buffer
    import bsg_cordic_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic [1:0]         cnt_q, cnt_d;
    logic [width_p-1:0] head_q, head_d;
    logic [width_p-1:0] tail_q, tail_d;
    logic               v_q, v_d;
    logic               ready_q, ready_d;
    logic               accept, xfer;

    assign accept = v_i & ready_q;
    assign xfer   = v_q & ready_i;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({accept, xfer})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = data_i;
                    cnt_d  = 2'd1;
                end else begin
                    tail_d = data_i;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end else begin
                    cnt_d  = 2'd0;
                end
            end
            // Both at once is only possible with exactly one entry held.
            2'b11: head_d = data_i;
            default: ;
        endcase
        v_d     = (cnt_d != 2'd0);
        ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            v_q     <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            v_q     <= v_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign v_o     = v_q;
    assign data_o  = head_q;

endmodule

`default_nettype wire

// File: rtl/bsg_cordic_sinh_cosh_input_stage.sv
//------------------------------------------------------------------------------
// Module : bsg_cordic_sinh_cosh_input_stage
// Desc   : Clamps input angles, seeds x/y and buffers the triple for the CORDIC core.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_cordic_sinh_cosh_input_stage
    import bsg_cordic_pkg::*;
#(
    parameter int                     ans_width_p     = c_ANS_WIDTH,
    parameter int                     ans_frac_p      = c_ANS_FRAC,
    parameter int                     ang_width_p     = c_ANG_WIDTH,
    parameter logic [ans_width_p-1:0] gain_inv_p      = ans_width_p'(1) << ans_frac_p,
    parameter logic [ang_width_p-1:0] ang_max_p       = c_ANG_MAX,
    parameter int                     sat_cnt_width_p = c_SAT_CNT_W
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [ang_width_p-1:0]     ang_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [ans_width_p-1:0]     x_o,
    output logic [ans_width_p-1:0]     y_o,
    output logic [ang_width_p-1:0]     ang_o,
    output logic                       sat_o,
    input  logic                       ready_i,
    output logic [sat_cnt_width_p-1:0] sat_cnt_o,
    input  logic                       clr_cnt_i
);

    localparam int c_PAYLOAD_W = 2 * ans_width_p + ang_width_p + 1;

    logic signed [ang_width_p-1:0] ang_s, max_s, min_s;
    logic [ang_width_p-1:0]        ang_clamped;
    logic                          sat;
    logic                          accept;
    logic [c_PAYLOAD_W-1:0]        payload_in, payload_out;
    logic [sat_cnt_width_p-1:0]    sat_cnt_q, sat_cnt_d;

    assign ang_s = $signed(ang_i);
    assign max_s = $signed(ang_max_p);
    assign min_s = -max_s;

    // Exactly +/-ang_max_p passes through unclamped.
    always_comb begin
        ang_clamped = ang_i;
        sat         = 1'b0;
        if (ang_s > max_s) begin
            ang_clamped = max_s;
            sat         = 1'b1;
        end else if (ang_s < min_s) begin
            ang_clamped = min_s;
            sat         = 1'b1;
        end
    end

    assign payload_in = {gain_inv_p, {ans_width_p{1'b0}}, ang_clamped, sat};
    assign accept     = v_i & ready_o;

    bsg_cordic_skid_buffer #(
        .width_p (c_PAYLOAD_W)
    ) u_skid (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (payload_in),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (payload_out),
        .ready_i   (ready_i)
    );

    assign {x_o, y_o, ang_o, sat_o} = payload_out;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (clr_cnt_i) begin
            sat_cnt_d = '0;
        end else if (accept && sat && (sat_cnt_q != {sat_cnt_width_p{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt_o = sat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_cordic_sinh_cosh_input_stage.sv
//------------------------------------------------------------------------------
// Module : tb_bsg_cordic_sinh_cosh_input_stage
// Desc   : Randomised self-checking bench with a queue-based reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_cordic_sinh_cosh_input_stage;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic [23:0] ang_i;
    logic        ready_o;
    logic        v_o;
    logic [23:0] x_o;
    logic [23:0] y_o;
    logic [23:0] ang_o;
    logic        sat_o;
    logic        ready_i;
    logic [15:0] sat_cnt_o;
    logic        clr_cnt_i;

    int passed = 0;
    int total  = 0;

    bsg_cordic_sinh_cosh_input_stage dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .ang_i     (ang_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .x_o       (x_o),
        .y_o       (y_o),
        .ang_o     (ang_o),
        .sat_o     (sat_o),
        .ready_i   (ready_i),
        .sat_cnt_o (sat_cnt_o),
        .clr_cnt_i (clr_cnt_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: an ordered list of {ang, sat} entries, max two deep.
    typedef struct { logic [23:0] ang; logic sat; } entry_t;
    entry_t mq[$];
    int     mcnt  = 0;
    int     n_out = 0;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mq.delete();
            mcnt = 0;
        end else begin
            automatic bit acc = v_i && (mq.size() < 2);
            automatic bit xf  = (mq.size() > 0) && ready_i;
            automatic int a   = int'($signed(ang_i));
            automatic entry_t e;
            if (a > 32'sh500000)       begin a = 32'sh500000;  e.sat = 1'b1; end
            else if (a < -32'sh500000) begin a = -32'sh500000; e.sat = 1'b1; end
            else                       e.sat = 1'b0;
            e.ang = a[23:0];
            if (xf) begin
                void'(mq.pop_front());
                n_out++;
            end
            if (acc) mq.push_back(e);
            if (clr_cnt_i) mcnt = 0;
            else if (acc && e.sat && mcnt < 65535) mcnt++;
        end
    end

    always @(negedge clk_i) begin
        if (reset_n_i) begin
            chk("v_o", {31'd0, v_o}, {31'd0, mq.size() > 0});
            chk("ready_o", {31'd0, ready_o}, {31'd0, mq.size() < 2});
            chk("sat_cnt_o", {16'd0, sat_cnt_o}, mcnt);
            if (mq.size() > 0) begin
                chk("ang_o", {8'd0, ang_o}, {8'd0, mq[0].ang});
                chk("sat_o", {31'd0, sat_o}, {31'd0, mq[0].sat});
                chk("x_o", {8'd0, x_o}, 32'h100000);
                chk("y_o", {8'd0, y_o}, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push_one(input logic [23:0] a);
        v_i = 1'b1; ang_i = a;
        tick();
        v_i = 1'b0;
        #3;
    endtask

    initial begin
        int base;
        reset_n_i = 1'b0; v_i = 1'b0; ang_i = '0; ready_i = 1'b1; clr_cnt_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 reset_n_i = 1'b1;
        #1;
        chk("rst v_o", {31'd0, v_o}, 32'd0);
        chk("rst ready_o", {31'd0, ready_o}, 32'd1);
        chk("rst ang_o", {8'd0, ang_o}, 32'd0);
        chk("rst x_o", {8'd0, x_o}, 32'd0);
        chk("rst sat_cnt", {16'd0, sat_cnt_o}, 32'd0);
        tick();

        // Pass-through with one-cycle latency
        push_one(24'h080000);
        chk("pt v_o", {31'd0, v_o}, 32'd1);
        chk("pt ang_o", {8'd0, ang_o}, 32'h080000);
        chk("pt x_o", {8'd0, x_o}, 32'h100000);
        chk("pt y_o", {8'd0, y_o}, 32'd0);
        chk("pt sat_o", {31'd0, sat_o}, 32'd0);
        tick();

        // Clamp boundaries
        push_one(24'h600000);
        chk("clamp hi ang", {8'd0, ang_o}, 32'h500000);
        chk("clamp hi sat", {31'd0, sat_o}, 32'd1);
        tick();
        push_one(24'hA00000);
        chk("clamp lo ang", {8'd0, ang_o}, 32'hB00000);
        chk("clamp lo sat", {31'd0, sat_o}, 32'd1);
        tick();
        push_one(24'h500000);
        chk("edge ang", {8'd0, ang_o}, 32'h500000);
        chk("edge sat", {31'd0, sat_o}, 32'd0);
        chk("clamp cnt", {16'd0, sat_cnt_o}, 32'd2);
        tick();
        push_one(24'hB00000);
        chk("edge neg sat", {31'd0, sat_o}, 32'd0);
        tick();

        // Backpressure: three offered, two held
        ready_i = 1'b0; v_i = 1'b1;
        ang_i = 24'h010000; tick();
        ang_i = 24'h020000; tick();
        ang_i = 24'h030000; tick();
        v_i = 1'b0;
        #3;
        chk("bp ready_o", {31'd0, ready_o}, 32'd0);
        chk("bp head", {8'd0, ang_o}, 32'h010000);
        tick(); #3;
        chk("bp head stable", {8'd0, ang_o}, 32'h010000);
        ready_i = 1'b1;
        tick(); #3;
        chk("bp second", {8'd0, ang_o}, 32'h020000);
        tick(); #3;
        chk("bp drained v", {31'd0, v_o}, 32'd0);
        chk("bp drained rdy", {31'd0, ready_o}, 32'd1);
        tick();

        // Streaming at full throughput
        base = n_out;
        ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            v_i = 1'b1; ang_i = 24'($urandom);
            tick();
        end
        v_i = 1'b0;
        tick(); tick();
        chk("stream count", n_out - base, 32'd100);

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            v_i       = ($urandom_range(0, 3) != 0);
            ready_i   = ($urandom_range(0, 2) != 0);
            clr_cnt_i = ($urandom_range(0, 15) == 0);
            ang_i     = ($urandom_range(0, 1) != 0) ? 24'($urandom) : 24'($urandom_range(0, 24'h0FFFFF));
            tick();
        end
        v_i = 1'b0; ready_i = 1'b1; clr_cnt_i = 1'b0;
        tick(); tick();

        // Counter saturation and clear priority
        clr_cnt_i = 1'b1; tick(); clr_cnt_i = 1'b0;
        v_i = 1'b1; ang_i = 24'h7FFFFF;
        repeat (65534) tick();
        #3 chk("cnt fffe", {16'd0, sat_cnt_o}, 32'h0000FFFE);
        repeat (3) tick();
        #3 chk("cnt fffF", {16'd0, sat_cnt_o}, 32'h0000FFFF);
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0; v_i = 1'b0;
        #3 chk("cnt clr", {16'd0, sat_cnt_o}, 32'd0);
        tick(); tick();

        // Asynchronous reset with both entries held
        ready_i = 1'b0; v_i = 1'b1; ang_i = 24'h700000;
        tick(); tick();
        v_i = 1'b0;
        #1 chk("pre-rst full", {31'd0, ready_o}, 32'd0);
        #1 reset_n_i = 1'b0;
        #1;
        chk("async v_o", {31'd0, v_o}, 32'd0);
        chk("async ready_o", {31'd0, ready_o}, 32'd1);
        chk("async sat_cnt", {16'd0, sat_cnt_o}, 32'd0);
        chk("async sat_o", {31'd0, sat_o}, 32'd0);
        tick();
        reset_n_i = 1'b1; ready_i = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
